picorv32_axi_arbiter: RTL
=========================

# picorv32_axi_arbiter

Two-master AXI4-Lite arbiter letting two `picorv32_axi` cores share one memory AXI4-Lite port. It sits between the cores' `mem_axi_*` ports and the single downstream memory/interconnect port. Arbitration is per transaction, with one outstanding transaction system-wide. Grant selection is round-robin by default, or fixed-priority to master 0.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate grants when both masters request; 0 = master 0 always wins ties.

Ports (`mK_` means one copy each for K = 0 and K = 1):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mK_axi_awvalid` / `mK_axi_awready`  in / out  1  master write-address handshake.
- `mK_axi_awaddr`  in  32  write address.
- `mK_axi_awprot`  in  3  write protection bits.
- `mK_axi_wvalid` / `mK_axi_wready`  in / out  1  master write-data handshake.
- `mK_axi_wdata`  in  32  write data.
- `mK_axi_wstrb`  in  4  write byte strobes.
- `mK_axi_bvalid` / `mK_axi_bready`  out / in  1  write-response handshake.
- `mK_axi_arvalid` / `mK_axi_arready`  in / out  1  read-address handshake.
- `mK_axi_araddr`  in  32  read address.
- `mK_axi_arprot`  in  3  read protection bits.
- `mK_axi_rvalid` / `mK_axi_rready`  out / in  1  read-data handshake.
- `mK_axi_rdata`  out  32  read data.
- `s_axi_*`  same signal set, directions mirrored, same widths; downstream memory port.

## Operation
- State register `state` ∈ {IDLE, WR, WB, RD, RR}. Grant register `gnt`: 0 or 1, reset 1, so the first tie goes to m0.
- Request: `reqK = mK_axi_awvalid | mK_axi_arvalid`.
- IDLE arbitration:
  - If only one master requests, it wins.
  - If both request, `ROUND_ROBIN=1` picks `!gnt`; `ROUND_ROBIN=0` picks m0.
  - Winner is loaded into `gnt`.
- Transaction type for the winner: if `awvalid` is set, go to WR; otherwise go to RD. A write wins over a read from the same master.
- WR:
  - `s_axi_awvalid = m[gnt]_awvalid & !aw_done` and `s_axi_wvalid = m[gnt]_wvalid & !w_done`.
  - `s_axi_awready` and `s_axi_wready` are forwarded only to `m[gnt]`.
  - `aw_done` / `w_done` flags set on the respective handshake, in either order or in the same cycle.
  - When both are done (a flag or the handshake in the current cycle), go to WB and clear both flags.
- WB: `m[gnt]_bvalid = s_axi_bvalid`; `s_axi_bready = m[gnt]_bready`. On the b handshake, go to IDLE.
- RD: `s_axi_arvalid = m[gnt]_arvalid`; `s_axi_arready` is forwarded to `m[gnt]`. On the handshake, go to RR.
- RR: `m[gnt]_rvalid = s_axi_rvalid`; `s_axi_rready = m[gnt]_rready`. On the r handshake, go to IDLE.
- Payload muxes (addr/prot/data/strb) select by `gnt` at all times. `s_axi_rdata` is broadcast to both `mK_axi_rdata`.
- Non-granted master: all its ready/valid outputs are held 0, so its requests stall and are never lost.
- All slave valid/ready outputs are 0 in IDLE.

## Timing
- Reset (synchronous): `state`=IDLE, `gnt`=1, flags cleared. In the cycle after reset is sampled, all valid/ready outputs on both sides are 0.
- Payload outputs are don't-care while their valid is low.
- Reset mid-transaction aborts it silently. No response is delivered to the master; the downstream port must be reset together with the arbiter.
- Arbitration latency: a request visible in IDLE at edge N produces `s_axi_a*valid` in cycle N+1 (registered state, combinational forwarding).
- Handshake pass-through is combinational; the arbiter adds zero cycles once granted.
- Minimum read occupancy is 3 cycles (IDLE, RD, RR). Minimum write occupancy is 3 cycles (IDLE, WR, WB).
- Back-to-back: one IDLE cycle is always inserted between transactions.
- AXI rule: once `s_axi_*valid` is asserted it must not drop before its handshake. Masters must hold valid (picorv32 does). Grant never changes outside IDLE.
- Starvation bound with `ROUND_ROBIN=1`: a requesting master waits at most one transaction of the other master.

## Test plan
- Single read: m0 `arvalid`, `araddr`=0x100 at cycle 2. Required: `s_axi_arvalid`=1 with `araddr`=0x100 in cycle 3. Slave `arready` in cycle 3 and `rvalid`/`rdata`=0x12345678 in cycle 5. Required: `m0_axi_rvalid`=1 with 0x12345678 in cycle 5; `m1_axi_rvalid`=0 throughout; IDLE in cycle 6.
- Tie, round-robin: both masters hold a read from cycle 2. Required: m0 is served first, then m1, then m0, alternating. With `ROUND_ROBIN=0`, m0 is served every time while its request stays asserted.
- Split write: m1 writes 0xDEADBEEF to 0x200 with `wstrb`=0xF. Slave `awready` at cycle k, `wready` at k+2, `bvalid` at k+4. Required: `s_axi_awvalid` drops after k; `m1_axi_bvalid`=1 at k+4; `m0_axi_bvalid`=0 throughout.
- Contention across types: m0 write in progress while m1 asserts `arvalid`. Required: `m1_axi_arready`=0 until the m0 b handshake; m1's read is issued one IDLE cycle later.
- Simultaneous AW/W handshake in the same cycle. Required: WB is entered the next cycle and there is no duplicate `s_axi_awvalid`.
- Reset asserted during RR. Required: all valid/ready outputs are 0 the next cycle and `gnt`=1. A new m1 read is then served normally.

Source files
------------

// File: rtl/picorv32_axi_arbiter_if.sv
// AXI4-Lite signal bundle shared by the cores' mem_axi ports and the downstream memory port.
// master modport drives requests and accepts responses; slave modport is the mirror image.
interface picorv32_axi_arbiter_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/picorv32_axi_arbiter.sv
// Two-master AXI4-Lite arbiter, one outstanding transaction; grant decided in IDLE (1 cycle),
// handshakes then pass through combinationally; the non-granted master stalls with readies held 0.
module picorv32_axi_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  picorv32_axi_arbiter_if.slave         m0_axi,
  picorv32_axi_arbiter_if.slave         m1_axi,
  picorv32_axi_arbiter_if.master        s_axi
);
  typedef enum logic [2:0] {IDLE, WR, WB, RD, RR} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic req0, req1, win;
  logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req0 = m0_axi.awvalid | m0_axi.arvalid;
  assign req1 = m1_axi.awvalid | m1_axi.arvalid;

  assign g_awvalid = gnt_q ? m1_axi.awvalid : m0_axi.awvalid;
  assign g_wvalid  = gnt_q ? m1_axi.wvalid  : m0_axi.wvalid;
  assign g_bready  = gnt_q ? m1_axi.bready  : m0_axi.bready;
  assign g_arvalid = gnt_q ? m1_axi.arvalid : m0_axi.arvalid;
  assign g_rready  = gnt_q ? m1_axi.rready  : m0_axi.rready;

  assign s_axi.awaddr = gnt_q ? m1_axi.awaddr : m0_axi.awaddr;
  assign s_axi.awprot = gnt_q ? m1_axi.awprot : m0_axi.awprot;
  assign s_axi.wdata  = gnt_q ? m1_axi.wdata  : m0_axi.wdata;
  assign s_axi.wstrb  = gnt_q ? m1_axi.wstrb  : m0_axi.wstrb;
  assign s_axi.araddr = gnt_q ? m1_axi.araddr : m0_axi.araddr;
  assign s_axi.arprot = gnt_q ? m1_axi.arprot : m0_axi.arprot;

  // Done flags mask the channel that already handshook so it is never re-issued downstream.
  assign s_axi.awvalid = (state_q == WR) && g_awvalid && !aw_done_q;
  assign s_axi.wvalid  = (state_q == WR) && g_wvalid  && !w_done_q;
  assign s_axi.bready  = (state_q == WB) && g_bready;
  assign s_axi.arvalid = (state_q == RD) && g_arvalid;
  assign s_axi.rready  = (state_q == RR) && g_rready;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign b_hs  = s_axi.bvalid  && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = s_axi.rvalid  && s_axi.rready;

  assign m0_axi.awready = (state_q == WR) && !gnt_q && !aw_done_q && s_axi.awready;
  assign m0_axi.wready  = (state_q == WR) && !gnt_q && !w_done_q  && s_axi.wready;
  assign m0_axi.bvalid  = (state_q == WB) && !gnt_q && s_axi.bvalid;
  assign m0_axi.arready = (state_q == RD) && !gnt_q && s_axi.arready;
  assign m0_axi.rvalid  = (state_q == RR) && !gnt_q && s_axi.rvalid;
  assign m0_axi.rdata   = s_axi.rdata;

  assign m1_axi.awready = (state_q == WR) && gnt_q && !aw_done_q && s_axi.awready;
  assign m1_axi.wready  = (state_q == WR) && gnt_q && !w_done_q  && s_axi.wready;
  assign m1_axi.bvalid  = (state_q == WB) && gnt_q && s_axi.bvalid;
  assign m1_axi.arready = (state_q == RD) && gnt_q && s_axi.arready;
  assign m1_axi.rvalid  = (state_q == RR) && gnt_q && s_axi.rvalid;
  assign m1_axi.rdata   = s_axi.rdata;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    win       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // gnt holds the last winner, so !gnt_q hands a tie to the other master.
          if (req0 && req1) win = ROUND_ROBIN ? !gnt_q : 1'b0;
          else              win = req1;
          gnt_d   = win;
          state_d = (win ? m1_axi.awvalid : m0_axi.awvalid) ? WR : RD;
        end
      end
      WR: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WB:      if (b_hs)  state_d = IDLE;
      RD:      if (ar_hs) state_d = RR;
      RR:      if (r_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule
